// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@60 timing constants, widths and pixel-bundle types
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_TOTAL  = 1056;
    localparam int V_ACTIVE = 600;
    localparam int V_TOTAL  = 628;
    localparam int CNT_W    = 11;
    localparam int COLOR_W  = 12;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        cnt_t hcount;
        cnt_t vcount;
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
    } timing_t;

    // One-bit-wider sum so lo+len never wraps at the top of the counter range.
    function automatic logic in_span(cnt_t c, cnt_t lo, logic [CNT_W:0] len);
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + len));
    endfunction

endpackage

// File: rtl/draw_rect_if.sv
// rtl/draw_rect_if.sv - pixel stream bundle: timing strobes, counters and RGB
interface draw_rect_if;
    import vga_pkg::*;

    cnt_t   hcount;
    cnt_t   vcount;
    logic   hsync;
    logic   vsync;
    logic   hblnk;
    logic   vblnk;
    color_t rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// rtl/vga_delay.sv - WIDTH x DEPTH register pipeline with asynchronous reset
module vga_delay #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_rect.sv
// rtl/draw_rect.sv - overlays a fixed-size rectangle on the VGA pixel stream, 2-cycle pipeline
// Optional outline colour on the rectangle's edge pixels: DRAW_RECT_BORDER_EN.
module draw_rect
    import vga_pkg::*;
#(
    parameter int     RECT_W       = 48,
    parameter int     RECT_H       = 64,
    parameter color_t RECT_COLOR   = 12'hF80,
    parameter color_t BORDER_COLOR = 12'h000
) (
    input  logic             pclk,
    input  logic             rst,
    draw_rect_if.slave       vga_in,
    draw_rect_if.master      vga_out,
    input  cnt_t             xpos,
    input  cnt_t             ypos
);

    localparam logic [CNT_W:0] W12 = (CNT_W+1)'(RECT_W);
    localparam logic [CNT_W:0] H12 = (CNT_W+1)'(RECT_H);

    timing_t timing_in;
    timing_t timing_s1;
    timing_t timing_s2;

    cnt_t   x_l;
    cnt_t   y_l;
    logic   vblnk_d;
    logic   in_rect;
    logic   in_rect_s1;
    logic   on_edge_s1;
    color_t rgb_s1;
    color_t rgb_mux;
    color_t rgb_q;

    assign timing_in = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                         hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                         hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk};

    vga_delay #(.WIDTH($bits(timing_t)), .DEPTH(1)) u_dly_s1 (
        .clk  (pclk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_s1)
    );

    vga_delay #(.WIDTH($bits(timing_t)), .DEPTH(1)) u_dly_s2 (
        .clk  (pclk),
        .rst  (rst),
        .din  (timing_s1),
        .dout (timing_s2)
    );

    // Position is sampled only at the start of vertical blanking so a frame never tears.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            x_l     <= '0;
            y_l     <= '0;
        end else begin
            vblnk_d <= vga_in.vblnk;
            if (vga_in.vblnk && !vblnk_d) begin
                x_l <= xpos;
                y_l <= ypos;
            end
        end
    end

    assign in_rect = in_span(vga_in.hcount, x_l, W12) && in_span(vga_in.vcount, y_l, H12);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            in_rect_s1 <= 1'b0;
            rgb_s1     <= '0;
        end else begin
            in_rect_s1 <= in_rect;
            rgb_s1     <= vga_in.rgb;
        end
    end

`ifdef DRAW_RECT_BORDER_EN
    logic on_edge;

    assign on_edge = in_rect &&
                     (({1'b0, vga_in.hcount} == {1'b0, x_l}) ||
                      ({1'b0, vga_in.hcount} == ({1'b0, x_l} + W12 - 1'b1)) ||
                      ({1'b0, vga_in.vcount} == {1'b0, y_l}) ||
                      ({1'b0, vga_in.vcount} == ({1'b0, y_l} + H12 - 1'b1)));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) on_edge_s1 <= 1'b0;
        else     on_edge_s1 <= on_edge;
    end
`else
    assign on_edge_s1 = 1'b0;
`endif

    always_comb begin
        rgb_mux = rgb_s1;
        if (timing_s1.hblnk || timing_s1.vblnk) rgb_mux = '0;
        else if (in_rect_s1)                    rgb_mux = on_edge_s1 ? BORDER_COLOR : RECT_COLOR;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_mux;
    end

    assign vga_out.hcount = timing_s2.hcount;
    assign vga_out.vcount = timing_s2.vcount;
    assign vga_out.hsync  = timing_s2.hsync;
    assign vga_out.vsync  = timing_s2.vsync;
    assign vga_out.hblnk  = timing_s2.hblnk;
    assign vga_out.vblnk  = timing_s2.vblnk;
    assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_rect.sv
// tb/tb_draw_rect.sv - self-checking bench for draw_rect against a frame-level reference model
module tb_draw_rect;
    import vga_pkg::*;

    localparam int          RW  = 48;
    localparam int          RH  = 64;
    localparam logic [11:0] RC  = 12'hF80;
    localparam logic [11:0] BC  = 12'h000;
    localparam logic [11:0] BG  = 12'h0F0;
`ifdef DRAW_RECT_BORDER_EN
    localparam logic [11:0] EDGE_C = BC;
`else
    localparam logic [11:0] EDGE_C = RC;
`endif

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] xpos;
    logic [10:0] ypos;

    draw_rect_if vin ();
    draw_rect_if vout ();

    draw_rect #(.RECT_W(RW), .RECT_H(RH), .RECT_COLOR(RC), .BORDER_COLOR(BC)) dut (
        .pclk    (pclk),
        .rst     (rst),
        .vga_in  (vin),
        .vga_out (vout),
        .xpos    (xpos),
        .ypos    (ypos)
    );

    always #5 pclk = ~pclk;

    wire [37:0] obs = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                       vout.hblnk, vout.vblnk, vout.rgb};

    int checks = 0;
    int errors = 0;
    int mx = 0;
    int my = 0;
    bit prev_vb = 1'b0;
    logic [37:0] exp_q [$];
    int          want_q [$];

    // What the screen should show: black in blanking, rectangle where it overlaps, else background.
    function automatic logic [11:0] ref_pixel(int h, int v, bit hb, bit vb, logic [11:0] rgb);
        if (hb || vb) return 12'h000;
        if (!(h >= mx && h < mx + RW && v >= my && v < my + RH)) return rgb;
`ifdef DRAW_RECT_BORDER_EN
        if (h == mx || h == mx + RW - 1 || v == my || v == my + RH - 1) return BC;
`endif
        return RC;
    endfunction

    // want: -1 no extra check, -2 must not be the fill colour, else exact rgb_out value.
    task automatic step(int h, int v, bit hs, bit vs, bit hb, bit vb, logic [11:0] rgb, int want);
        logic [37:0] e;
        int          w;
        vin.hcount = h[10:0];
        vin.vcount = v[10:0];
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        exp_q.push_back({h[10:0], v[10:0], hs, vs, hb, vb, ref_pixel(h, v, hb, vb, rgb)});
        want_q.push_back(want);
        if (vb && !prev_vb) begin
            mx = int'(xpos);
            my = int'(ypos);
        end
        prev_vb = vb;
        @(posedge pclk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            w = want_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL pipe h=%0d v=%0d got %h exp %h", e[37:27], e[26:16], obs, e);
            end
            if (w >= 0) begin
                checks++;
                assert (obs[11:0] === w[11:0]) else begin
                    errors++;
                    $error("FAIL pixel h=%0d v=%0d got %h exp %h", e[37:27], e[26:16], obs[11:0], w[11:0]);
                end
            end else if (w == -2) begin
                checks++;
                assert (obs[11:0] !== RC) else begin
                    errors++;
                    $error("FAIL offscreen h=%0d v=%0d got %h exp not %h", e[37:27], e[26:16], obs[11:0], RC);
                end
            end
        end
    endtask

    task automatic pixel(int h, int v, logic [11:0] rgb, int want);
        step(h, v, (h >= 840 && h < 968), (v >= 601 && v < 605),
             (h >= H_ACTIVE), (v >= V_ACTIVE), rgb, want);
    endtask

    task automatic new_frame(int x, int y);
        xpos = x[10:0];
        ypos = y[10:0];
        pixel(H_TOTAL - 1, V_ACTIVE - 1, 12'h123, -1);
        pixel(0, V_ACTIVE, 12'h456, -1);
        pixel(1, V_ACTIVE, 12'h789, -1);
    endtask

    task automatic flush();
        pixel(1000, 0, 12'h000, -1);
        pixel(1001, 0, 12'h000, -1);
    endtask

    initial begin
        logic [11:0] r;
        int lo, hi, vlo, vhi, x, y;

        rst  = 1'b1;
        xpos = '0;
        ypos = '0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        assert (obs === 38'd0) else begin
            errors++;
            $error("FAIL reset_state got %h exp %h", obs, 38'd0);
        end
        rst = 1'b0;

        // placement
        new_frame(100, 50);
        pixel(100, 50, BG, EDGE_C);
        pixel(147, 113, BG, EDGE_C);
        pixel(99, 50, BG, BG);
        pixel(148, 50, BG, BG);
        pixel(100, 114, BG, BG);
        pixel(120, 80, BG, RC);
`ifdef DRAW_RECT_BORDER_EN
        pixel(100, 60, BG, BC);
        pixel(147, 60, BG, BC);
        pixel(101, 60, BG, RC);
`endif
        flush();

        // latency: single-cycle hsync pulse with a unique hcount sequence
        for (int h = 500; h < 508; h++) step(h, 20, (h == 503), 1'b0, 1'b0, 1'b0, 12'(h * 7), -1);
        flush();

        // frame latch: mid-frame xpos change waits for the next vblank edge
        new_frame(100, 280);
        xpos = 11'd400;
        pixel(100, 300, BG, EDGE_C);
        pixel(120, 300, BG, RC);
        pixel(400, 300, BG, BG);
        pixel(99, 300, BG, BG);
        new_frame(400, 280);
        pixel(420, 300, BG, RC);
        pixel(100, 300, BG, BG);
        pixel(448, 300, BG, BG);
        flush();

        // right-edge clipping and horizontal wrap
        new_frame(780, 0);
        for (int h = 770; h < 812; h++)
            pixel(h, 10, BG, (h == 780) ? int'(EDGE_C) : (h > 780 && h < 800) ? int'(RC) : (h >= 800) ? 0 : int'(BG));
        for (int h = 1050; h < H_TOTAL; h++) pixel(h, 10, BG, 0);
        for (int h = 0; h < 4; h++) pixel(h, 11, BG, BG);
        flush();

        // fully off-screen position
        new_frame(1000, 0);
        for (int h = 0; h < H_TOTAL; h++) begin
            r = 12'($urandom);
            if (r == RC) r = 12'h001;
            pixel(h, 10, r, -2);
        end
        flush();

        // randomized positions, with position jitter between latches
        for (int it = 0; it < 12; it++) begin
            x = $urandom_range(850, 0);
            y = $urandom_range(650, 0);
            new_frame(x, y);
            xpos = 11'($urandom);
            ypos = 11'($urandom);
            lo  = (x > 4) ? x - 4 : 0;
            hi  = (x + RW + 4 < H_TOTAL) ? x + RW + 4 : H_TOTAL - 1;
            vlo = (y > 4) ? y - 4 : 0;
            vhi = (y + RH + 4 < V_TOTAL) ? y + RH + 4 : V_TOTAL - 1;
            for (int k = 0; k < 60; k++)
                pixel($urandom_range(hi, lo), $urandom_range(vhi, vlo), 12'($urandom), -1);
        end
        flush();

        // reset mid-line, then the rectangle defaults to (0,0)
        new_frame(290, 10);
        for (int h = 296; h <= 300; h++) pixel(h, 20, BG, -1);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        assert (obs === 38'd0) else begin
            errors++;
            $error("FAIL reset_async got %h exp %h", obs, 38'd0);
        end
        @(posedge pclk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        want_q.delete();
        mx = 0;
        my = 0;
        prev_vb = 1'b0;
        xpos = 11'd300;
        ypos = 11'd300;
        pixel(10, 10, BG, RC);
        pixel(50, 10, BG, BG);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
